jk_latch_driver: RTL and testbench

JK_LATCH_DRIVER -- requirements
Module: jk_latch_driver

---
 rtl/jk_latch_driver.sv | 195 +++++++++++++++++++
 tb/tb_jk_latch_driver.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/jk_latch_driver.sv
// jk_latch_driver: sequences J/K/EN onto an external JK latch for one command
// at a time (setup -> enable pulse -> hold -> readback check). A shadow copy of
// the expected latch state is kept so the readback can be verified.
module jk_latch_driver #(
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  output logic       cmd_ready,
  output logic       j,
  output logic       k,
  output logic       en,
  input  logic       q_in,
  input  logic       qb_in,
  output logic       done,
  output logic       q_exp,
  output logic       err,
  input  logic       err_clr
);

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_RESET  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  // The counter only runs from 0 to (length-1) of the longest phase, so it
  // never has to hold the full parameter value and cannot wrap inside a state.
  localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  // Last count value of each timed phase; zero-length phases are skipped
  // entirely, so their "last" value is never used.
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'((PULSE_CYC > 0) ? PULSE_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    CHECK = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             q_exp_q, q_exp_d;
  logic             err_q, err_d;
  logic             j_q, j_d;
  logic             k_q, k_d;
  logic             en_q, en_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             mismatch;

  assign cmd_ready = ready_q;
  assign j         = j_q;
  assign k         = k_q;
  assign en        = en_q;
  assign done      = done_q;
  assign q_exp     = q_exp_q;
  assign err       = err_q;

  // State, counter, shadow state and all output registers (async reset).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_exp_q <= 1'b0;
      err_q   <= 1'b0;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      en_q    <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_exp_q <= q_exp_d;
      err_q   <= err_d;
      j_q     <= j_d;
      k_q     <= k_d;
      en_q    <= en_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  // Latched command opcode; pure data, only meaningful while a command runs.
  always_ff @(posedge clk) begin
    op_q <= op_d;
  end

  // Next-state, phase counter, shadow-state update and sticky error.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    q_exp_d = q_exp_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && ready_q) begin
          op_d    = cmd_op;
          cnt_d   = '0;
          state_d = (SETUP_CYC > 0) ? SETUP : PULSE;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = PULSE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PULSE: begin
        // A toggle is given a single enable cycle so the latch flips once.
        if ((op_q == OP_TOGGLE) || (cnt_q == PULSE_LAST)) begin
          cnt_d   = '0;
          state_d = (HOLD_CYC > 0) ? HOLD : CHECK;
          unique case (op_q)
            OP_HOLD:   q_exp_d = q_exp_q;
            OP_RESET:  q_exp_d = 1'b0;
            OP_SET:    q_exp_d = 1'b1;
            OP_TOGGLE: q_exp_d = ~q_exp_q;
            default:   q_exp_d = q_exp_q;
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CHECK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Readback is sampled as CHECK is entered so err is visible during CHECK;
    // q_exp_d covers the zero-hold case where q_exp updates on the same edge.
    mismatch = (q_in != q_exp_d) || (qb_in != ~q_in);
    if ((state_d == CHECK) && mismatch) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Output values derived from the next state so every output is a flop.
  always_comb begin
    j_d     = 1'b0;
    k_d     = 1'b0;
    en_d    = 1'b0;
    ready_d = 1'b0;
    done_d  = 1'b0;
    unique case (state_d)
      IDLE: begin
        ready_d = 1'b1;
      end
      SETUP, HOLD: begin
        j_d = op_d[1];
        k_d = op_d[0];
      end
      PULSE: begin
        j_d  = op_d[1];
        k_d  = op_d[0];
        en_d = 1'b1;
      end
      CHECK: begin
        done_d = 1'b1;
      end
      default: begin
        ready_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_jk_latch_driver.sv
// Directed bench for jk_latch_driver with a behavioural JK latch on its pins.
module tb_jk_latch_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic       cmd_ready;
  logic       j, k, en;
  logic       q_in, qb_in;
  logic       done, q_exp, err;
  logic       err_clr = 1'b0;

  logic       lat_q = 1'b0;
  logic       fault = 1'b0;

  int n_cmp = 0;
  int n_mis = 0;

  jk_latch_driver #(.SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_ready (cmd_ready),
    .j         (j),
    .k         (k),
    .en        (en),
    .q_in      (q_in),
    .qb_in     (qb_in),
    .done      (done),
    .q_exp     (q_exp),
    .err       (err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  // Behavioural latch: applies J/K once per clock while enabled.
  always @(posedge clk) begin
    if (en) begin
      case ({j, k})
        2'b01:   lat_q <= 1'b0;
        2'b10:   lat_q <= 1'b1;
        2'b11:   lat_q <= ~lat_q;
        default: lat_q <= lat_q;
      endcase
    end
  end

  assign q_in  = fault ? 1'b0 : lat_q;
  assign qb_in = ~lat_q;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issues one command from IDLE; cycle 1 is the accept cycle.
  task automatic run_cmd(input string tag, input logic [1:0] op, input int exp_en,
                         input int exp_done, input int exp_q, input int exp_err);
    int en_cnt, done_at, err_at, q_at, rdy_at, jk_at_done;
    int jk_en;
    en_cnt = 0; done_at = 0; err_at = -1; q_at = -1; rdy_at = -1;
    jk_at_done = -1; jk_en = -1;
    @(negedge clk);
    check_eq({tag, "_ready"}, int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    @(posedge clk);
    for (int c = 2; c <= 20 && done_at == 0; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (en) begin
        en_cnt++;
        jk_en = int'({j, k});
      end
      if (done) begin
        done_at    = c;
        err_at     = int'(err);
        q_at       = int'(q_exp);
        rdy_at     = int'(cmd_ready);
        jk_at_done = int'({j, k});
      end
    end
    check_eq({tag, "_en_cycles"}, en_cnt, exp_en);
    check_eq({tag, "_jk_in_pulse"}, jk_en, int'(op));
    check_eq({tag, "_done_cycle"}, done_at, exp_done);
    check_eq({tag, "_q_exp"}, q_at, exp_q);
    check_eq({tag, "_err"}, err_at, exp_err);
    check_eq({tag, "_ready_at_done"}, rdy_at, 0);
    check_eq({tag, "_jk_at_done"}, jk_at_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1, acc2, done1, done2, busy_rdy, n_done;

    // Reset values, applied asynchronously before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_ready", int'(cmd_ready), 1);
    check_eq("rst_en", int'(en), 0);
    check_eq("rst_jk", int'({j, k}), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_q_exp", int'(q_exp), 0);
    check_eq("rst_err", int'(err), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Toggle twice from reset: one enable cycle, done in cycle 5.
    run_cmd("tog1", 2'b11, 1, 5, 1, 0);
    check_eq("tog1_latch", int'(lat_q), 1);
    run_cmd("tog2", 2'b11, 1, 5, 0, 0);
    check_eq("tog2_latch", int'(lat_q), 0);

    // Set then reset: two enable cycles, done in cycle 6.
    run_cmd("set", 2'b10, 2, 6, 1, 0);
    run_cmd("reset", 2'b01, 2, 6, 0, 0);
    check_eq("reset_latch", int'(lat_q), 0);

    // Hold after set leaves both shadow and latch at 1.
    run_cmd("set2", 2'b10, 2, 6, 1, 0);
    run_cmd("hold", 2'b00, 2, 6, 1, 0);
    check_eq("hold_latch", int'(lat_q), 1);

    // Readback fault: err sticky until cleared.
    fault = 1'b1;
    run_cmd("fault", 2'b10, 2, 6, 1, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("err_sticky", int'(err), 1);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check_eq("err_cleared", int'(err), 0);

    // Clear held across a mismatching check: set wins, then clear takes over.
    err_clr = 1'b1;
    run_cmd("setwins", 2'b10, 2, 6, 1, 1);
    @(negedge clk);
    check_eq("setwins_then_clear", int'(err), 0);
    err_clr = 1'b0;
    fault   = 1'b0;

    // Back-to-back: cmd_valid held high across two commands.
    acc1 = 0; acc2 = 0; done1 = 0; done2 = 0; busy_rdy = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    for (int c = 1; c <= 30 && done2 == 0; c++) begin
      if (c > 1) @(negedge clk);
      if (acc2 != 0 && c > acc2) cmd_valid = 1'b0;
      if (acc1 != 0 && c > acc1 && (done1 == 0 || c <= done1) && cmd_ready) busy_rdy++;
      if (done && done1 == 0) done1 = c;
      else if (done && acc2 != 0) done2 = c;
      if (cmd_ready && cmd_valid) begin
        if (acc1 == 0) acc1 = c;
        else if (acc2 == 0) acc2 = c;
      end
    end
    cmd_valid = 1'b0;
    check_eq("b2b_accept1", acc1, 1);
    check_eq("b2b_done1", done1, 6);
    check_eq("b2b_ready_while_busy", busy_rdy, 0);
    check_eq("b2b_accept2", acc2, 7);
    check_eq("b2b_done2", done2, 12);

    // Reset pulsed during the enable pulse of a RESET command.
    @(negedge clk);
    check_eq("abort_q_before", int'(q_exp), 1);
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 10 && !en; i++) @(negedge clk);
    check_eq("abort_in_pulse", int'(en), 1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_en", int'(en), 0);
    check_eq("abort_ready", int'(cmd_ready), 1);
    check_eq("abort_q_exp", int'(q_exp), 0);
    check_eq("abort_jk", int'({j, k}), 0);
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 1) rst_n = 1'b1;
      if (done) n_done++;
    end
    check_eq("abort_no_done", n_done, 0);
    check_eq("abort_idle_ready", int'(cmd_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
